maxpool2d: RTL and testbench

//  Downstream stage of the conv2 conv+ReLU block. Snapshots the finished
//  (SIZE x SIZE) feature map when conv signals done, and reduces it by

---
 rtl/maxpool2d.sv | 161 ++++++++++++++++
 tb/tb_maxpool2d.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2d.sv
// Max-pooling stage behind conv2: snapshots the finished feature map on start,
// scans each POOL x POOL window one element per cycle and emits the pooled map.
module maxpool2d #(
  parameter int SIZE      = 5,
  parameter int POOL      = 2,
  parameter int STRIDE    = 2,
  parameter int WIDTH_BIT = 8,
  localparam int OUT      = (SIZE - POOL) / STRIDE + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic signed [WIDTH_BIT-1:0] inpMatrix [SIZE][SIZE],
  output logic signed [WIDTH_BIT-1:0] poolOut   [OUT][OUT],
  output logic                        busy,
  output logic                        done
);

  localparam int NK = POOL * POOL;
  localparam int KW = (NK > 1) ? $clog2(NK) : 1;
  localparam int OW = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int RW = (SIZE > 1) ? $clog2(SIZE) : 1;

  generate
    if (POOL > SIZE || POOL < 1 || STRIDE < 1) begin : g_bad_params
      $error("maxpool2d: illegal parameters SIZE=%0d POOL=%0d STRIDE=%0d", SIZE, POOL, STRIDE);
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WRITE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic                        start_q;
  logic                        start_rise;
  logic signed [WIDTH_BIT-1:0] snap_q [SIZE][SIZE];
  logic signed [WIDTH_BIT-1:0] snap_d [SIZE][SIZE];
  logic signed [WIDTH_BIT-1:0] pool_q [OUT][OUT];
  logic signed [WIDTH_BIT-1:0] pool_d [OUT][OUT];
  logic [OW-1:0]               wi_q, wi_d;
  logic [OW-1:0]               wj_q, wj_d;
  logic [KW-1:0]               k_q, k_d;
  logic signed [WIDTH_BIT-1:0] max_q, max_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic [RW-1:0]               row_idx;
  logic [RW-1:0]               col_idx;
  logic signed [WIDTH_BIT-1:0] elem;

  assign start_rise = start & ~start_q;

  // Element k of the current window, taken in raster order from the snapshot.
  always_comb begin
    row_idx = RW'(int'(wi_q) * STRIDE + int'(k_q) / POOL);
    col_idx = RW'(int'(wj_q) * STRIDE + int'(k_q) % POOL);
    elem    = snap_q[row_idx][col_idx];
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    pool_d  = pool_q;
    wi_d    = wi_q;
    wj_d    = wj_q;
    k_d     = k_q;
    max_d   = max_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_rise) begin
          snap_d  = inpMatrix;
          wi_d    = '0;
          wj_d    = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end

      SCAN: begin
        // First element loads unconditionally so all-negative windows pool correctly.
        if (k_q == '0) begin
          max_d = elem;
        end else if (elem > max_q) begin
          max_d = elem;
        end
        if (k_q == KW'(NK - 1)) begin
          state_d = WRITE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      WRITE: begin
        pool_d[wi_q][wj_q] = max_q;
        k_d                = '0;
        if (wj_q == OW'(OUT - 1)) begin
          wj_d = '0;
          if (wi_q == OW'(OUT - 1)) begin
            state_d = DONE;
          end else begin
            wi_d    = wi_q + OW'(1);
            state_d = SCAN;
          end
        end else begin
          wj_d    = wj_q + OW'(1);
          state_d = SCAN;
        end
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      snap_q  <= '{default: '0};
      pool_q  <= '{default: '0};
      wi_q    <= '0;
      wj_q    <= '0;
      k_q     <= '0;
      max_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      snap_q  <= snap_d;
      pool_q  <= pool_d;
      wi_q    <= wi_d;
      wj_q    <= wj_d;
      k_q     <= k_d;
      max_q   <= max_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign poolOut = pool_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_maxpool2d.sv
// Directed bench for maxpool2d: a table of 5x5 maps with hand-computed pooled
// results, plus sequences for snapshot, busy-restart, held start, reset and a 7x7/3/2 build.
module tb_maxpool2d;

  logic clock;
  logic reset;
  logic start;
  logic signed [7:0] in_m  [5][5];
  logic signed [7:0] out_m [2][2];
  logic busy;
  logic done;

  logic big_start;
  logic signed [7:0] big_in  [7][7];
  logic signed [7:0] big_out [3][3];
  logic big_busy;
  logic big_done;

  int checks = 0;
  int errors = 0;

  maxpool2d #(.SIZE(5), .POOL(2), .STRIDE(2), .WIDTH_BIT(8)) u_dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .inpMatrix(in_m),
    .poolOut  (out_m),
    .busy     (busy),
    .done     (done)
  );

  maxpool2d #(.SIZE(7), .POOL(3), .STRIDE(2), .WIDTH_BIT(8)) u_big (
    .clock    (clock),
    .reset    (reset),
    .start    (big_start),
    .inpMatrix(big_in),
    .poolOut  (big_out),
    .busy     (big_busy),
    .done     (big_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string          name;
    int             kind;
    int             val;
    int             sr;
    int             sc;
    int             sv;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [3:0][7:0] pack4(input int e00, input int e01, input int e10, input int e11);
    return {8'(e11), 8'(e10), 8'(e01), 8'(e00)};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic fillMap(input vec_t v);
    int x;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        case (v.kind)
          0:       x = r * 5 + c;
          1:       x = v.val;
          2:       x = ((r + c) % 2 == 1) ? 127 : -128;
          3:       x = 24 - (r * 5 + c);
          default: x = (r == 4 || c == 4) ? 100 : 0;
        endcase
        if (v.kind == 1 && r == v.sr && c == v.sc) x = v.sv;
        in_m[r][c] = 8'(x);
      end
    end
  endtask

  task automatic checkPool(input vec_t v, input string tag);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        checkOutput($sformatf("%s %s pool[%0d][%0d]", tag, v.name, i, j),
                    int'(out_m[i][j]), int'($signed(v.exp[i * 2 + j])));
      end
    end
  endtask

  // Caller raises start first; this waits for the capture edge and then counts
  // cycles until done. mode 1: overwrite input, 2: re-pulse start mid-pass,
  // 3: hold start high, 4: assert reset at cycle 12 and return.
  task automatic applyStimulus(input int mode, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    @(posedge clock);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        break;
      end
      if (mode != 3 && i == 0) start = 1'b0;
      if (mode == 1 && i == 2) begin
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++) in_m[r][c] = 8'sd127;
      end
      if (mode == 2 && i == 10) start = 1'b1;
      if (mode == 2 && i == 11) start = 1'b0;
      if (mode == 4 && i == 12) begin
        reset = 1'b1;
        lat   = i;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not terminate");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int bcnt;
    int extra;
    int exp_big;

    vecs[0] = '{"ramp",      0, 0,    0, 0, 0,   pack4(6, 8, 16, 18)};
    vecs[1] = '{"neg_r3c2",  1, -5,   3, 2, -1,  pack4(-5, -5, -5, -1)};
    vecs[2] = '{"neg_r3c1",  1, -5,   3, 1, -1,  pack4(-5, -5, -1, -5)};
    vecs[3] = '{"checker",   2, 0,    0, 0, 0,   pack4(127, 127, 127, 127)};
    vecs[4] = '{"descend",   3, 0,    0, 0, 0,   pack4(24, 22, 14, 12)};
    vecs[5] = '{"dropped",   4, 0,    0, 0, 0,   pack4(0, 0, 0, 0)};
    vecs[6] = '{"extremes",  1, -128, 2, 3, 127, pack4(-128, -128, -128, 127)};

    reset     = 1'b1;
    start     = 1'b0;
    big_start = 1'b0;
    fillMap(vecs[5]);
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) big_in[r][c] = '0;

    repeat (3) @(negedge clock);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkPool(vecs[5], "reset");
    reset = 1'b0;

    foreach (vecs[n]) begin
      fillMap(vecs[n]);
      start = 1'b1;
      applyStimulus(0, lat, bcnt);
      checkOutput({vecs[n].name, " latency"}, lat, 21);
      checkOutput({vecs[n].name, " busy cycles"}, bcnt, 21);
      checkPool(vecs[n], "table");
      @(negedge clock);
      checkOutput({vecs[n].name, " done one cycle"}, int'(done), 0);
    end

    $display("[TB] snapshot: input overwritten two cycles after capture");
    fillMap(vecs[0]);
    start = 1'b1;
    applyStimulus(1, lat, bcnt);
    checkOutput("snapshot latency", lat, 21);
    checkPool(vecs[0], "snapshot");

    $display("[TB] start while busy, then back-to-back pass");
    fillMap(vecs[4]);
    start = 1'b1;
    applyStimulus(2, lat, bcnt);
    checkOutput("busy restart latency", lat, 21);
    checkPool(vecs[4], "busy restart");
    fillMap(vecs[3]);
    start = 1'b1;
    applyStimulus(0, lat, bcnt);
    checkOutput("back-to-back latency", lat, 21);
    checkOutput("back-to-back busy cycles", bcnt, 21);
    checkPool(vecs[3], "back-to-back");

    $display("[TB] start held high for the whole pass");
    @(negedge clock);
    fillMap(vecs[1]);
    start = 1'b1;
    applyStimulus(3, lat, bcnt);
    checkOutput("held start latency", lat, 21);
    checkPool(vecs[1], "held start");
    extra = 0;
    repeat (6) begin
      @(negedge clock);
      if (busy || done) extra++;
    end
    checkOutput("held start no second pass", extra, 0);
    start = 1'b0;
    @(negedge clock);

    $display("[TB] reset in the middle of a pass");
    fillMap(vecs[0]);
    start = 1'b1;
    applyStimulus(4, lat, bcnt);
    #1;
    checkOutput("mid-reset busy", int'(busy), 0);
    checkOutput("mid-reset done", int'(done), 0);
    checkPool(vecs[5], "mid-reset");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    fillMap(vecs[6]);
    start = 1'b1;
    applyStimulus(0, lat, bcnt);
    checkOutput("post-reset latency", lat, 21);
    checkPool(vecs[6], "post-reset");

    $display("[TB] SIZE=7 POOL=3 STRIDE=2 instance");
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++) big_in[r][c] = 8'(r + c);
    big_in[6][6] = 8'sd100;
    @(negedge clock);
    big_start = 1'b1;
    @(posedge clock);
    lat  = -1;
    bcnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (big_busy) bcnt++;
      if (big_done) begin
        lat = i;
        break;
      end
      if (i == 0) big_start = 1'b0;
    end
    checkOutput("big latency", lat, 91);
    checkOutput("big busy cycles", bcnt, 91);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        exp_big = (i == 2 && j == 2) ? 100 : 2 * (i + j) + 4;
        checkOutput($sformatf("big pool[%0d][%0d]", i, j), int'(big_out[i][j]), exp_big);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
